// File: rtl/exe_apb_pkg.sv
// exe_apb_pkg: slave register map, status width, step encoding, FSM states and step-to-address helper
package exe_apb_pkg;
  localparam logic [1:0] ADDR_OPER   = 2'd0;
  localparam logic [1:0] ADDR_ARGA   = 2'd1;
  localparam logic [1:0] ADDR_ARGB   = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam int STATUS_W = 4;
  localparam int STEP_W   = 3;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_EXE_WAIT, S_RSP} state_t;
  function automatic logic [1:0] step_addr(input logic [STEP_W-1:0] step);
    return step == 3'd0 ? ADDR_OPER : step == 3'd1 ? ADDR_ARGA : step == 3'd2 ? ADDR_ARGB :
           step == 3'd3 ? ADDR_RESULT : ADDR_STATUS;
  endfunction
endpackage

// File: rtl/apb_exe_cmd_master_if.sv
// apb_exe_cmd_master_if: APB bus between the command master and the execution-unit slave
//   master modport drives PADDR/PSEL/PENABLE/PWRITE/PWDATA, samples PRDATA/PREADY/PSLVERR
//   slave modport is the mirror image
interface apb_exe_cmd_master_if #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_xfer_engine.sv
// apb_xfer_engine: one APB SETUP/ACCESS transfer per i_start, back-to-back capable, registered bus outputs
//   i_PCLK, i_PRESETn (async, active-low)
//   i_start/i_addr/i_write/i_wdata : launch a transfer (only while idle or in the completing cycle)
//   o_done : ACCESS completes this cycle; o_err : completion is a slave error or timeout
//   o_rdata : PRDATA pass-through; bus : APB master modport
//   Optional APB_EXE_MASTER_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles without PREADY
module apb_xfer_engine
  import exe_apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 48,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESETn,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata,
  apb_exe_cmd_master_if.master  bus
);
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  w_tmo;
`ifdef APB_EXE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  // r_cnt counts ACCESS cycles already spent waiting; firing on the last allowed one drops PSEL next edge
  assign w_tmo = r_penable && !bus.PREADY && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_PCLK or negedge i_PRESETn)
    if (!i_PRESETn) r_cnt <= '0;
    else r_cnt <= (r_penable && !o_done) ? r_cnt + 1'b1 : '0;
`else
  assign w_tmo = 1'b0;
`endif
  assign o_done  = r_penable && (bus.PREADY || w_tmo);
  assign o_err   = r_penable && ((bus.PREADY && bus.PSLVERR) || w_tmo);
  assign o_rdata = bus.PRDATA;
  assign bus.PSEL    = r_psel;
  assign bus.PENABLE = r_penable;
  assign bus.PWRITE  = r_pwrite;
  assign bus.PADDR   = r_paddr;
  assign bus.PWDATA  = r_pwdata;
  always_ff @(posedge i_PCLK or negedge i_PRESETn)
    if (!i_PRESETn) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_psel    <= i_start || (r_psel && !o_done);
      r_penable <= !i_start && r_psel && !o_done;
      r_pwrite  <= i_start ? i_write : r_pwrite && !o_done;
      r_paddr   <= i_start ? i_addr : o_done ? '0 : r_paddr;
      r_pwdata  <= i_start ? (i_write ? i_wdata : '0) : o_done ? '0 : r_pwdata;
    end
endmodule

// File: rtl/apb_exe_cmd_master.sv
// apb_exe_cmd_master: takes one (oper, argA, argB) command, writes it to the execution-unit slave, waits, reads result/status back
//   i_PCLK, i_PRESETn (async, active-low)
//   i_cmd_valid/o_cmd_ready, i_cmd_oper/i_cmd_argA/i_cmd_argB : command port
//   o_rsp_valid/i_rsp_ready, o_rsp_result/o_rsp_status/o_rsp_err : response port
//   apb : APB master modport
//   Optional APB_EXE_MASTER_TIMEOUT_EN enables the ACCESS-phase timeout in apb_xfer_engine
module apb_exe_cmd_master
  import exe_apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 48,
  parameter int ADDR_WIDTH     = 16,
  parameter int EXE_WAIT       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESETn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [DATA_WIDTH-1:0] i_cmd_oper,
  input  logic [DATA_WIDTH-1:0] i_cmd_argA,
  input  logic [DATA_WIDTH-1:0] i_cmd_argB,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_result,
  output logic [STATUS_W-1:0]   o_rsp_status,
  output logic                  o_rsp_err,
  apb_exe_cmd_master_if.master  apb
);
  localparam int WAIT_W = EXE_WAIT > 1 ? $clog2(EXE_WAIT) : 1;
  state_t                r_state, w_state_n;
  logic [STEP_W-1:0]     r_step, w_step_n;
  logic [WAIT_W-1:0]     r_wait, w_wait_n;
  logic [DATA_WIDTH-1:0] r_arga, r_argb;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid, w_rsp_valid_n;
  logic [DATA_WIDTH-1:0] r_rsp_result, w_rsp_result_n;
  logic [STATUS_W-1:0]   r_rsp_status, w_rsp_status_n;
  logic                  r_rsp_err, w_rsp_err_n;
  logic                  w_accept, w_start, w_done, w_xerr;
  logic [DATA_WIDTH-1:0] w_rdata, w_wdata;
  assign w_accept = r_state == S_IDLE && i_cmd_valid && r_cmd_ready;
  // step 0 is only launched from IDLE, so oper goes straight from the port into the PWDATA register
  assign w_wdata = w_step_n == 3'd0 ? i_cmd_oper : w_step_n == 3'd1 ? r_arga : r_argb;
  apb_xfer_engine #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_xfer (
    .i_PCLK(i_PCLK),
    .i_PRESETn(i_PRESETn),
    .i_start(w_start),
    .i_addr(ADDR_WIDTH'(step_addr(w_step_n))),
    .i_write(w_step_n < 3'd3),
    .i_wdata(w_wdata),
    .o_done(w_done),
    .o_err(w_xerr),
    .o_rdata(w_rdata),
    .bus(apb)
  );
  always_comb begin
    w_state_n      = r_state;
    w_step_n       = r_step;
    w_wait_n       = r_wait;
    w_start        = 1'b0;
    w_rsp_valid_n  = r_rsp_valid;
    w_rsp_result_n = r_rsp_result;
    w_rsp_status_n = r_rsp_status;
    w_rsp_err_n    = r_rsp_err;
    case (r_state)
      S_IDLE:
        if (w_accept) begin
          w_start        = 1'b1;
          w_step_n       = '0;
          w_state_n      = S_SETUP;
          w_rsp_result_n = '0;
          w_rsp_status_n = '0;
          w_rsp_err_n    = 1'b0;
        end
      S_SETUP: w_state_n = S_ACCESS;
      S_ACCESS:
        if (w_done) begin
          if (w_xerr) begin
            w_state_n      = S_RSP;
            w_rsp_valid_n  = 1'b1;
            w_rsp_err_n    = 1'b1;
            w_rsp_result_n = '0;
            w_rsp_status_n = '0;
          end else if (r_step == 3'd2 && EXE_WAIT != 0) begin
            w_state_n = S_EXE_WAIT;
            w_wait_n  = '0;
          end else if (r_step == 3'd4) begin
            w_state_n      = S_RSP;
            w_rsp_valid_n  = 1'b1;
            w_rsp_status_n = w_rdata[STATUS_W-1:0];
          end else begin
            w_start        = 1'b1;
            w_step_n       = r_step + 3'd1;
            w_state_n      = S_SETUP;
            w_rsp_result_n = r_step == 3'd3 ? w_rdata : r_rsp_result;
          end
        end
      S_EXE_WAIT:
        if (r_wait == WAIT_W'(EXE_WAIT - 1)) begin
          w_start   = 1'b1;
          w_step_n  = 3'd3;
          w_state_n = S_SETUP;
        end else w_wait_n = r_wait + 1'b1;
      S_RSP:
        if (i_rsp_ready) begin
          w_rsp_valid_n = 1'b0;
          w_state_n     = S_IDLE;
        end
      default: w_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge i_PCLK or negedge i_PRESETn)
    if (!i_PRESETn) begin
      r_state      <= S_IDLE;
      r_step       <= '0;
      r_wait       <= '0;
      r_arga       <= '0;
      r_argb       <= '0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_status <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_step       <= w_step_n;
      r_wait       <= w_wait_n;
      r_cmd_ready  <= w_state_n == S_IDLE;
      r_rsp_valid  <= w_rsp_valid_n;
      r_rsp_result <= w_rsp_result_n;
      r_rsp_status <= w_rsp_status_n;
      r_rsp_err    <= w_rsp_err_n;
      if (w_accept) begin
        r_arga <= i_cmd_argA;
        r_argb <= i_cmd_argB;
      end
    end
  assign o_cmd_ready  = r_cmd_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_status = r_rsp_status;
  assign o_rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_apb_exe_cmd_master.sv
// tb_apb_exe_cmd_master: directed tests of apb_exe_cmd_master against a behavioural APB slave
module tb_apb_exe_cmd_master;
  localparam int DW = 48;
  localparam int AW = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  logic          cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic          cmd_ready, rsp_valid, rsp_err;
  logic [DW-1:0] oper = '0, arga = '0, argb = '0;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_status;
  apb_exe_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb ();
  apb_exe_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .EXE_WAIT(2), .TIMEOUT_CYCLES(8)) dut (
    .i_PCLK(clk),
    .i_PRESETn(rstn),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_oper(oper),
    .i_cmd_argA(arga),
    .i_cmd_argB(argb),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result),
    .o_rsp_status(rsp_status),
    .o_rsp_err(rsp_err),
    .apb(apb)
  );
  logic [DW-1:0] rd_result = 48'h1234_5678_9ABC;
  logic [DW-1:0] rd_status = 48'hFFFF_0000_00A5;
  int   xfer_cnt = 0, acc_cnt = 0, cyc = 0;
  int   base = 0, wait_step = -1, wait_n = 0, err_step = -1;
  logic hang = 1'b0;
  logic [AW-1:0] log_addr [64];
  logic [DW-1:0] log_data [64];
  logic          log_wr   [64];
  logic acc;
  assign acc         = apb.PSEL && apb.PENABLE;
  assign apb.PREADY  = acc && !hang && ((xfer_cnt - base) != wait_step || acc_cnt >= wait_n);
  assign apb.PSLVERR = apb.PREADY && (xfer_cnt - base) == err_step;
  assign apb.PRDATA  = apb.PADDR == 16'd1 ? rd_status : rd_result;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    acc_cnt <= (acc && !apb.PREADY) ? acc_cnt + 1 : 0;
    if (apb.PREADY) begin
      log_addr[xfer_cnt % 64] <= apb.PADDR;
      log_data[xfer_cnt % 64] <= apb.PWDATA;
      log_wr[xfer_cnt % 64]   <= apb.PWRITE;
      xfer_cnt <= xfer_cnt + 1;
    end
  end
  int n_cmp = 0, n_bad = 0, t_hs = 0, lat = 0;

  task automatic send_cmd(input logic [DW-1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    oper = o; arga = a; argb = b; cmd_valid = 1'b1; t_hs = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; oper = '1; arga = '1; argb = '1;
  endtask

  task automatic wait_rsp(output int l);
    int k = 0;
    while (!rsp_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    l = cyc - t_hs;
  endtask

  task automatic ack_rsp;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, apb.PSEL, apb.PENABLE, apb.PWRITE} !== 6'b0 ||
        apb.PADDR !== '0 || apb.PWDATA !== '0 || rsp_result !== '0 || rsp_status !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b err=%b psel=%b pen=%b pwr=%b paddr=%0h pwdata=%0h result=%0h status=%0h required all 0",
               cmd_ready, rsp_valid, rsp_err, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, rsp_result, rsp_status);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_rise: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_zero_wait;
    int            ea [5] = '{0, 1, 2, 0, 1};
    logic          ew [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [DW-1:0] ed [5] = '{48'd1, 48'd5, 48'd7, 48'd0, 48'd0};
    base = xfer_cnt;
    send_cmd(48'd1, 48'd5, 48'd7);
    @(negedge clk);
    n_cmp++;
    if ({apb.PSEL, apb.PENABLE, apb.PWRITE} !== 3'b101 || apb.PADDR !== 16'd0 || apb.PWDATA !== 48'd1 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_first_setup: sel/en/wr=%b%b%b addr=%0h wdata=%0h ready=%b required 101 0 1 0",
               apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, cmd_ready);
    end
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 13) begin
      n_bad++;
      $display("FAIL zw_latency: got %0d required 13", lat);
    end
    n_cmp++;
    if (rsp_result !== 48'h1234_5678_9ABC || rsp_status !== 4'h5 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_rsp_fields: result=%0h status=%0h err=%b required 123456789abc 5 0", rsp_result, rsp_status, rsp_err);
    end
    n_cmp++;
    if (xfer_cnt - base !== 5) begin
      n_bad++;
      $display("FAIL zw_xfer_count: got %0d required 5", xfer_cnt - base);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (log_addr[(base + i) % 64] !== AW'(ea[i]) || log_wr[(base + i) % 64] !== ew[i] || log_data[(base + i) % 64] !== ed[i]) begin
        n_bad++;
        $display("FAIL zw_xfer%0d: addr=%0h wr=%b data=%0h required addr=%0h wr=%b data=%0h", i,
                 log_addr[(base + i) % 64], log_wr[(base + i) % 64], log_data[(base + i) % 64], ea[i], ew[i], ed[i]);
      end
    end
    ack_rsp;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL zw_after_ack: valid=%b ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_wait_states;
    int k = 0;
    base = xfer_cnt; wait_step = 1; wait_n = 3;
    send_cmd(48'd2, 48'hABC, 48'd4);
    while (!(acc && apb.PADDR == 16'd1) && k < 30) begin
      @(negedge clk);
      k++;
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_cmp++;
      if ({apb.PSEL, apb.PENABLE, apb.PWRITE} !== 3'b111 || apb.PADDR !== 16'd1 || apb.PWDATA !== 48'hABC) begin
        n_bad++;
        $display("FAIL ws_hold%0d: sel/en/wr=%b%b%b addr=%0h wdata=%0h required 111 1 abc", j,
                 apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA);
      end
    end
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 16) begin
      n_bad++;
      $display("FAIL ws_latency: got %0d required 16", lat);
    end
    n_cmp++;
    if (log_data[(base + 1) % 64] !== 48'hABC || log_data[(base + 2) % 64] !== 48'd4 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ws_data: argA=%0h argB=%0h err=%b required abc 4 0", log_data[(base + 1) % 64], log_data[(base + 2) % 64], rsp_err);
    end
    wait_step = -1;
    ack_rsp;
  endtask

  task automatic test_slverr;
    base = xfer_cnt; err_step = 2;
    send_cmd(48'd3, 48'd4, 48'd5);
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 7) begin
      n_bad++;
      $display("FAIL err_latency: got %0d required 7", lat);
    end
    n_cmp++;
    if (rsp_err !== 1'b1 || rsp_result !== '0 || rsp_status !== 4'h0 || apb.PSEL !== 1'b0) begin
      n_bad++;
      $display("FAIL err_rsp_fields: err=%b result=%0h status=%0h psel=%b required 1 0 0 0", rsp_err, rsp_result, rsp_status, apb.PSEL);
    end
    err_step = -1;
    ack_rsp;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (xfer_cnt - base !== 3) begin
      n_bad++;
      $display("FAIL err_no_reads: transfers=%0d required 3", xfer_cnt - base);
    end
  endtask

  task automatic test_backpressure;
    base = xfer_cnt;
    send_cmd(48'd6, 48'd7, 48'd8);
    wait_rsp(lat);
    oper = 48'd9; arga = 48'd10; argb = 48'd11; cmd_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || apb.PSEL !== 1'b0 || rsp_result !== 48'h1234_5678_9ABC || rsp_status !== 4'h5) begin
        n_bad++;
        $display("FAIL bp_stall%0d: valid=%b ready=%b psel=%b result=%0h status=%0h required 1 0 0 123456789abc 5", j,
                 rsp_valid, cmd_ready, apb.PSEL, rsp_result, rsp_status);
      end
    end
    ack_rsp;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || apb.PSEL !== 1'b0 || xfer_cnt - base !== 5) begin
      n_bad++;
      $display("FAIL bp_idle: ready=%b psel=%b transfers=%0d required 1 0 5", cmd_ready, apb.PSEL, xfer_cnt - base);
    end
    t_hs = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({apb.PSEL, apb.PENABLE} !== 2'b10 || apb.PADDR !== 16'd0 || apb.PWDATA !== 48'd9) begin
      n_bad++;
      $display("FAIL bp_next_cmd: sel/en=%b%b addr=%0h wdata=%0h required 10 0 9", apb.PSEL, apb.PENABLE, apb.PADDR, apb.PWDATA);
    end
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 13 || log_data[(base + 6) % 64] !== 48'd10 || log_data[(base + 7) % 64] !== 48'd11) begin
      n_bad++;
      $display("FAIL bp_next_rsp: latency=%0d argA=%0h argB=%0h required 13 a b", lat, log_data[(base + 6) % 64], log_data[(base + 7) % 64]);
    end
    ack_rsp;
  endtask

  task automatic test_reset_mid;
    int k = 0;
    send_cmd(48'd1, 48'd2, 48'd3);
    while (!(acc && !apb.PWRITE && apb.PADDR == 16'd0) && k < 30) begin
      @(negedge clk);
      k++;
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, apb.PSEL, apb.PENABLE, apb.PWRITE} !== 6'b0 || apb.PADDR !== '0 || apb.PWDATA !== '0 || rsp_result !== '0) begin
      n_bad++;
      $display("FAIL rm_async_clear: ready=%b valid=%b err=%b sel/en/wr=%b%b%b addr=%0h wdata=%0h result=%0h required all 0",
               cmd_ready, rsp_valid, rsp_err, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, rsp_result);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_after_release: valid=%b ready=%b required 0 1", rsp_valid, cmd_ready);
    end
    base = xfer_cnt;
    send_cmd(48'd4, 48'd5, 48'd6);
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 13 || log_addr[base % 64] !== 16'd0 || log_data[base % 64] !== 48'd4 ||
        log_data[(base + 1) % 64] !== 48'd5 || log_data[(base + 2) % 64] !== 48'd6) begin
      n_bad++;
      $display("FAIL rm_full_rerun: latency=%0d addr0=%0h d0=%0h d1=%0h d2=%0h required 13 0 4 5 6", lat,
               log_addr[base % 64], log_data[base % 64], log_data[(base + 1) % 64], log_data[(base + 2) % 64]);
    end
    ack_rsp;
  endtask

`ifdef APB_EXE_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    base = xfer_cnt; hang = 1'b1;
    send_cmd(48'd1, 48'd1, 48'd1);
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 10 || rsp_err !== 1'b1 || rsp_result !== '0 || apb.PSEL !== 1'b0 || xfer_cnt - base !== 0) begin
      n_bad++;
      $display("FAIL to_abort: latency=%0d err=%b result=%0h psel=%b transfers=%0d required 10 1 0 0 0",
               lat, rsp_err, rsp_result, apb.PSEL, xfer_cnt - base);
    end
    hang = 1'b0;
    ack_rsp;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_zero_wait;
    test_wait_states;
    test_slverr;
    test_backpressure;
    test_reset_mid;
`ifdef APB_EXE_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
